// File: rtl/pattern_sweeper_if.sv
// rtl/pattern_sweeper_if.sv - stimulus/response bundle between the sweeper and its driver
interface pattern_sweeper_if;
  logic        start;
  logic        y;
  logic        a, b, c, d, e, f;
  logic        busy;
  logic        done;
  logic [63:0] truth;
  logic [6:0]  ones;

  modport master (
    output start, y,
    input  a, b, c, d, e, f, busy, done, truth, ones
  );

  modport slave (
    input  start, y,
    output a, b, c, d, e, f, busy, done, truth, ones
  );
endinterface

// File: rtl/pattern_sweeper.sv
// rtl/pattern_sweeper.sv - walks all 64 input vectors of a 6-input unit and captures its truth table
module pattern_sweeper #(
  parameter int SETTLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  pattern_sweeper_if.slave sw
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [1:0]  state;
  logic [5:0]  v;
  logic [3:0]  settle_cnt;
  logic [63:0] truth;
  logic [6:0]  ones;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      v          <= 6'd0;
      settle_cnt <= 4'd0;
      truth      <= 64'd0;
      ones       <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sw.start) begin
            state      <= RUN;
            v          <= 6'd0;
            truth      <= 64'd0;
            ones       <= 7'd0;
            settle_cnt <= SETTLE_LD;
          end
        end
        RUN: begin
          // counter reaching 1 marks the last settle cycle: this edge samples y
          if (settle_cnt <= 4'd1) begin
            truth[v] <= sw.y;
            ones     <= ones + {6'd0, sw.y};
            if (v == 6'd63) begin
              state      <= DONE;
              v          <= 6'd0;
              settle_cnt <= 4'd0;
            end else begin
              v          <= v + 6'd1;
              settle_cnt <= SETTLE_LD;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {sw.a, sw.b, sw.c, sw.d, sw.e, sw.f} = v;
  assign sw.busy  = (state == RUN);
  assign sw.done  = (state == DONE);
  assign sw.truth = truth;
  assign sw.ones  = ones;

endmodule
